// File: rtl/mult_div_pkg.sv
// Shared types and default sizing for the multiply/divide chain sequencer.
package mult_div_pkg;

  localparam int MD_WORD       = 26;
  localparam int MUL_STEPS_DEF = 13;
  localparam int DIV_STEPS_DEF = 26;
  localparam int CNT_W         = 5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    CHK  = 3'd2,
    RUN  = 3'd3,
    HOLD = 3'd4
  } state_e;

  localparam logic [2:0] S_IDLE = IDLE;
  localparam logic [2:0] S_LOAD = LOAD;
  localparam logic [2:0] S_CHK  = CHK;
  localparam logic [2:0] S_RUN  = RUN;
  localparam logic [2:0] S_HOLD = HOLD;

endpackage

// File: rtl/mult_div_seq_if.sv
// Command/strobe bundle between decode logic, the sequencer and the MR/Q/PR chain.
interface mult_div_seq_if;
  import mult_div_pkg::*;

  logic             START;
  logic             OPDIV;
  logic             ABORT;
  logic             DPOVF;
  logic             ACK;
  logic             BUSY;
  logic             MRLD;
  logic             PRCLR;
  logic             STEP;
  logic             DIVMODE;
  logic [CNT_W-1:0] STEPNO;
  logic             DONE;
  logic             ERR;

  modport master (
    output START, OPDIV, ABORT, DPOVF, ACK,
    input  BUSY, MRLD, PRCLR, STEP, DIVMODE, STEPNO, DONE, ERR
  );

  modport slave (
    input  START, OPDIV, ABORT, DPOVF, ACK,
    output BUSY, MRLD, PRCLR, STEP, DIVMODE, STEPNO, DONE, ERR
  );
endinterface

// File: rtl/mult_div_seq.sv
// Sequencer issuing load/clear/step strobes to the multiply/divide register chain.
// Every output is a decode of registered state, so no input reaches an output combinationally.
module mult_div_seq
  import mult_div_pkg::*;
#(
  parameter int WORD      = MD_WORD,
  parameter int MUL_STEPS = MUL_STEPS_DEF,
  parameter int DIV_STEPS = DIV_STEPS_DEF
) (
  input  logic          CLK,
  input  logic          RSTN,
  mult_div_seq_if.slave bus
);

  if (MUL_STEPS < 1 || MUL_STEPS > 31 || DIV_STEPS < 1 || DIV_STEPS > 31) begin : g_bad_steps
    $error("mult_div_seq: step counts must lie in 1..31 for the 5-bit step counter");
  end
  if (WORD > 2 * MUL_STEPS || WORD > DIV_STEPS) begin : g_bad_word
    $error("mult_div_seq: step counts do not cover the full word length");
  end

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_STEPS - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_STEPS - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] last_step;

  assign last_step = div_q ? DIV_LAST : MUL_LAST;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          state_d = S_LOAD;
          div_d   = bus.OPDIV;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = div_q ? S_CHK : S_RUN;
      end
      S_CHK: begin
        if (bus.DPOVF) begin
          state_d = S_HOLD;
          err_d   = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q == last_step) begin
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (bus.ACK) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          div_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        div_d   = 1'b0;
        err_d   = 1'b0;
      end
    endcase

    // Abort overrides every active-state transition, including the final step.
    if (bus.ABORT && (state_q == S_LOAD || state_q == S_CHK || state_q == S_RUN)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      div_d   = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      err_q   <= err_d;
    end
  end

  assign bus.BUSY    = (state_q != S_IDLE);
  assign bus.MRLD    = (state_q == S_LOAD);
  assign bus.PRCLR   = (state_q == S_LOAD);
  assign bus.STEP    = (state_q == S_RUN);
  assign bus.DIVMODE = div_q;
  assign bus.STEPNO  = cnt_q;
  assign bus.DONE    = (state_q == S_HOLD);
  assign bus.ERR     = err_q;

endmodule

// File: tb/tb_mult_div_seq.sv
// Scoreboard bench: commands push expected outcomes, a negedge monitor pops and compares.
module tb_mult_div_seq;

  logic CLK;
  logic RSTN;
  int   cyc;
  int   errors;
  int   checks;

  typedef struct {
    bit completes;
    bit err;
    bit div;
    int steps;
    int lat;
  } exp_t;

  exp_t exp_q[$];
  bit   mon_active;

  mult_div_seq_if bus ();

  mult_div_seq dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic exp_t make_exp(input bit completes, input bit div, input bit ovf, input int steps);
    exp_t e;
    e.completes = completes;
    e.div       = div;
    e.err       = div & ovf;
    e.steps     = steps;
    e.lat       = !div ? 14 : (ovf ? 2 : 28);
    return e;
  endfunction

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!bus.DONE && n < 60) begin
      tick();
      n++;
    end
    chk(name, bus.DONE, 1);
  endtask

  task automatic wait_step(input int idx, input string name);
    int n;
    n = 0;
    while (!(bus.STEP && bus.STEPNO == 5'(idx)) && n < 60) begin
      tick();
      n++;
    end
    chk(name, bus.STEPNO, idx);
  endtask

  task automatic ack_and_check(input string name);
    bus.ACK = 1'b1;
    tick();
    bus.ACK   = 1'b0;
    bus.DPOVF = 1'b0;
    bus.OPDIV = 1'b0;
    chk({name, "_busy"}, bus.BUSY, 0);
    chk({name, "_done"}, bus.DONE, 0);
    chk({name, "_err"}, bus.ERR, 0);
    chk({name, "_divmode"}, bus.DIVMODE, 0);
  endtask

  task automatic run_cmd(input string name, input bit div, input bit ovf, input int hold);
    exp_q.push_back(make_exp(1'b1, div, ovf, !div ? 13 : (ovf ? 0 : 26)));
    bus.START = 1'b1;
    bus.OPDIV = div;
    bus.DPOVF = ovf;
    tick();
    bus.START = 1'b0;
    wait_done({name, "_done_seen"});
    chk({name, "_err_at_done"}, bus.ERR, div & ovf);
    chk({name, "_divmode_at_done"}, bus.DIVMODE, div);
    repeat (hold) tick();
    chk({name, "_done_held"}, bus.DONE, 1);
    ack_and_check(name);
  endtask

  // Monitor: tracks one command from MRLD until BUSY falls.
  initial begin
    bit   done_seen;
    bit   div_s;
    int   steps;
    int   mrld_c;
    exp_t e;
    mon_active = 1'b0;
    done_seen  = 1'b0;
    div_s      = 1'b0;
    steps      = 0;
    mrld_c     = 0;
    forever begin
      @(negedge CLK);
      if (bus.PRCLR !== bus.MRLD) chk("prclr_eq_mrld", bus.PRCLR, bus.MRLD);
      if (bus.MRLD) begin
        if (mon_active) chk("mrld_while_active", 1, 0);
        mon_active = 1'b1;
        done_seen  = 1'b0;
        steps      = 0;
        mrld_c     = cyc;
        div_s      = bus.DIVMODE;
      end
      if (!mon_active) begin
        if (bus.STEP) chk("step_outside_cmd", bus.STEP, 0);
        if (bus.DONE) chk("done_outside_cmd", bus.DONE, 0);
      end else begin
        if (bus.STEP) begin
          if (done_seen) chk("step_after_done", bus.STEP, 0);
          chk("stepno_seq", bus.STEPNO, steps);
          steps++;
        end
        if (bus.DONE && !done_seen) begin
          done_seen = 1'b1;
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("completes", 1, e.completes);
            chk("step_count", steps, e.steps);
            chk("latency", cyc - mrld_c, e.lat);
            chk("err_flag", bus.ERR, e.err);
            chk("divmode_latched", div_s, e.div);
          end
        end
        if (!bus.BUSY) begin
          if (!done_seen) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_cancel", 1, 0);
            end else begin
              e = exp_q.pop_front();
              chk("cancel_expected", 0, e.completes);
              chk("cancel_step_count", steps, e.steps);
            end
          end
          mon_active = 1'b0;
        end
      end
    end
  end

  initial begin
    errors    = 0;
    checks    = 0;
    RSTN      = 1'b0;
    bus.START = 1'b0;
    bus.OPDIV = 1'b0;
    bus.ABORT = 1'b0;
    bus.DPOVF = 1'b0;
    bus.ACK   = 1'b0;
    repeat (3) tick();
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_mrld", bus.MRLD, 0);
    chk("rst_step", bus.STEP, 0);
    chk("rst_done", bus.DONE, 0);
    chk("rst_err", bus.ERR, 0);
    chk("rst_stepno", bus.STEPNO, 0);
    RSTN = 1'b1;

    // Multiply from reset: DONE cycle 15, ACK in cycle 17, idle in cycle 18.
    run_cmd("mul", 1'b0, 1'b0, 2);
    tick();
    run_cmd("div", 1'b1, 1'b0, 1);
    tick();
    run_cmd("div_ovf", 1'b1, 1'b1, 1);
    tick();

    // Abort during multiply RUN at STEPNO=5.
    exp_q.push_back(make_exp(1'b0, 1'b0, 1'b0, 6));
    bus.START = 1'b1;
    bus.OPDIV = 1'b0;
    tick();
    bus.START = 1'b0;
    wait_step(5, "abort_reach_step5");
    bus.ABORT = 1'b1;
    tick();
    bus.ABORT = 1'b0;
    chk("abort_busy", bus.BUSY, 0);
    chk("abort_done", bus.DONE, 0);
    repeat (3) tick();
    chk("abort_stays_idle", bus.BUSY, 0);
    run_cmd("mul_after_abort", 1'b0, 1'b0, 0);
    tick();

    // START pulses in RUN and HOLD are ignored; ACK+START leaves the block idle.
    exp_q.push_back(make_exp(1'b1, 1'b0, 1'b0, 13));
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    repeat (4) tick();
    bus.START = 1'b1;
    bus.OPDIV = 1'b1;
    tick();
    bus.START = 1'b0;
    chk("run_start_divmode", bus.DIVMODE, 0);
    wait_done("ign_done_seen");
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    chk("hold_start_done", bus.DONE, 1);
    bus.START = 1'b1;
    bus.ACK   = 1'b1;
    tick();
    bus.START = 1'b0;
    bus.ACK   = 1'b0;
    bus.OPDIV = 1'b0;
    chk("ackstart_busy", bus.BUSY, 0);
    tick();
    chk("ackstart_no_load", bus.MRLD, 0);
    chk("ackstart_still_idle", bus.BUSY, 0);

    // Reset during divide RUN at STEPNO=10.
    exp_q.push_back(make_exp(1'b0, 1'b1, 1'b0, 11));
    bus.START = 1'b1;
    bus.OPDIV = 1'b1;
    tick();
    bus.START = 1'b0;
    wait_step(10, "rst_reach_step10");
    RSTN = 1'b0;
    tick();
    RSTN      = 1'b1;
    bus.OPDIV = 1'b0;
    chk("midrst_busy", bus.BUSY, 0);
    chk("midrst_step", bus.STEP, 0);
    chk("midrst_divmode", bus.DIVMODE, 0);
    chk("midrst_stepno", bus.STEPNO, 0);
    chk("midrst_done", bus.DONE, 0);
    repeat (3) tick();

    chk("scoreboard_empty", exp_q.size(), 0);
    chk("monitor_idle", mon_active, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_div_seq.md
# mult_div_seq

Sequencer for the multiply/divide register chain (MR, Q, PR shift stages).
- Accepts one multiply or divide command at a time from the processor and generates the load, clear and step strobes that drive the chain for the required number of steps.
- Detects divide overflow and reports completion through a held done/acknowledge handshake.
- Sits between the instruction-decode logic and the multiply/divide datapath; it holds no operand data.

## Interface
Parameters:
- WORD, 26: data word length in bits.
- MUL_STEPS, 13: step strobes per multiply (two multiplier bits retired per step).
- DIV_STEPS, 26: step strobes per divide (one quotient bit per step).

Ports:
- CLK  in  1: single system clock; all state changes on the rising edge.
- RSTN  in  1: reset, synchronous, active-low.
- START  in  1: command request; honoured only while BUSY=0.
- OPDIV  in  1: command type, sampled with START; 0 = multiply, 1 = divide.
- ABORT  in  1: cancel the operation in progress.
- DPOVF  in  1: divide-overflow flag from the datapath, valid in the cycle after MRLD.
- ACK  in  1: consumer has taken the result.
- BUSY  out  1: a command is accepted and not yet acknowledged.
- MRLD  out  1: load MR from the operand bus, one-cycle pulse.
- PRCLR  out  1: clear PR and Q, one-cycle pulse coincident with MRLD.
- STEP  out  1: advance the chain by one step, one pulse per cycle while stepping.
- DIVMODE  out  1: registered copy of OPDIV, held from accept until idle.
- STEPNO  out  5: index of the current step, 0-based.
- DONE  out  1: result valid, held until ACK.
- ERR  out  1: divide overflow; valid while DONE=1.

## Operation
States: IDLE, LOAD, CHK, RUN, HOLD.

IDLE
- BUSY=0; all strobes 0.
- START=1 → LOAD. DIVMODE latches OPDIV on the same edge.

LOAD
- One cycle; MRLD=1, PRCLR=1, step counter cleared to 0.
- Next state: CHK if DIVMODE=1, else RUN.

CHK (divide only)
- One cycle; DPOVF is sampled here.
- DPOVF=1 → HOLD with ERR=1; no STEP is issued.
- DPOVF=0 → RUN.

RUN
- STEP=1 every cycle; STEPNO = counter value.
- Counter increments by 1 each cycle.
- On the cycle where counter = LIMIT-1 (LIMIT = MUL_STEPS or DIV_STEPS) → HOLD.

HOLD
- DONE=1; ERR holds its value.
- ACK=1 → IDLE; ERR, DONE and DIVMODE clear on that edge.

ABORT
- ABORT=1 in LOAD, CHK or RUN → IDLE next edge with no DONE pulse. The STEP/MRLD asserted in that cycle still occurs.
- ABORT in IDLE or HOLD is ignored.

Width rule:
- Counter is 5 bits. A parameter exceeding 31 is illegal; assert at elaboration.

## Timing
- Reset (RSTN=0 at an edge): state IDLE; BUSY, MRLD, PRCLR, STEP, DIVMODE, DONE, ERR all 0; STEPNO=0. Reset mid-operation discards the command immediately; no DONE.
- All outputs are registered-state decodes; no combinational path from inputs to outputs.
- Accept edge = cycle 0. MRLD/PRCLR high in cycle 1.
- Multiply: STEP high cycles 2..14, DONE from cycle 15. Latency START→DONE = 15 cycles.
- Divide without overflow: CHK in cycle 2, STEP cycles 3..28, DONE from cycle 29.
- Divide overflow: DONE=1, ERR=1 from cycle 3.
- START while BUSY=1 is ignored; it is not queued.
- ACK and START both high in HOLD: ACK is honoured and START is ignored; the next command needs START in IDLE, giving a minimum 1-cycle gap.
- ACK outside HOLD is ignored.
- ABORT and the final RUN cycle together: ABORT wins and no DONE is raised.

## Structure
- Shared package mult_div_pkg:
  - state enum (IDLE, LOAD, CHK, RUN, HOLD);
  - default step-count constants;
  - WORD.
- Single module; no sub-module needed. The step counter is inline.

## Test plan
- Multiply: START=1, OPDIV=0 from reset → MRLD/PRCLR in cycle 1, exactly 13 STEP pulses with STEPNO 0..12, DONE from cycle 15, ERR=0. ACK in cycle 17 → BUSY=0 in cycle 18.
- Divide, no overflow: OPDIV=1, DPOVF=0 → 26 STEP pulses (STEPNO 0..25), DONE from cycle 29, ERR=0, DIVMODE=1 until ACK.
- Divide overflow: OPDIV=1, DPOVF=1 in CHK → zero STEP pulses, DONE=1 and ERR=1 in cycle 3; ACK clears both.
- ABORT in multiply RUN at STEPNO=5 → BUSY=0 next cycle, STEP count total 6, DONE never asserts. A new START is then accepted normally.
- START pulses during RUN and during HOLD are ignored (only one DONE). ACK+START together in HOLD → IDLE, no new LOAD.
- RSTN=0 in divide RUN at STEPNO=10 → all outputs 0 on the next cycle; STEPNO=0.
